// File: rtl/vx_gbar_arbiter_pkg.sv
// Shared types and width helpers for the global barrier arbiter.
// Default widths correspond to a 4-core, 8-barrier cluster.
package vx_gbar_arbiter_pkg;

  localparam int GBAR_NUM_CORES    = 4;
  localparam int GBAR_NUM_BARRIERS = 8;

  // $clog2 that never returns 0, so single-entry configurations keep 1-bit fields
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GBAR_NB_WIDTH  = clog2_min1(GBAR_NUM_BARRIERS);
  localparam int GBAR_NC_WIDTH  = clog2_min1(GBAR_NUM_CORES);
  localparam int GBAR_CNT_WIDTH = GBAR_NC_WIDTH + 1;

  typedef struct packed {
    logic [GBAR_NB_WIDTH-1:0] id;
    logic [GBAR_NC_WIDTH-1:0] size_m1;
    logic [GBAR_NC_WIDTH-1:0] core_id;
  } gbar_req_t;

endpackage

// File: rtl/vx_gbar_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves past the winner only when the grant is accepted.
module vx_gbar_rr_arbiter
  import vx_gbar_arbiter_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int IDX_WIDTH = clog2_min1(NUM_REQS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  valid,
  input  logic                 accept,
  output logic [NUM_REQS-1:0]  grant,
  output logic [IDX_WIDTH-1:0] grant_index,
  output logic                 grant_valid
);

  logic [IDX_WIDTH-1:0] ptr_reg;
  logic [IDX_WIDTH-1:0] ptr_next;
  logic [IDX_WIDTH:0]   sum;
  logic [IDX_WIDTH-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    sum         = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      sum = {1'b0, ptr_reg} + (IDX_WIDTH+1)'(i);
      if (sum >= (IDX_WIDTH+1)'(NUM_REQS)) begin
        sum = sum - (IDX_WIDTH+1)'(NUM_REQS);
      end
      cand = sum[IDX_WIDTH-1:0];
      if (!grant_valid && valid[cand]) begin
        grant_valid = 1'b1;
        grant_index = cand;
      end
    end
    grant = grant_valid ? (NUM_REQS'(1) << grant_index) : '0;

    ptr_next = ptr_reg;
    if (accept) begin
      ptr_next = (grant_index == IDX_WIDTH'(NUM_REQS - 1)) ? '0 : grant_index + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/vx_gbar_arbiter.sv
// Cluster global barrier controller: one arrival per cycle, per-barrier arrival
// masks, one-cycle release broadcast. Optional counters under GBAR_PERF_EN.
module vx_gbar_arbiter
  import vx_gbar_arbiter_pkg::*;
#(
  parameter int NUM_CORES    = GBAR_NUM_CORES,
  parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
  parameter int NB_WIDTH     = clog2_min1(NUM_BARRIERS),
  parameter int NC_WIDTH     = clog2_min1(NUM_CORES)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CORES-1:0]                req_valid,
  input  logic [NUM_CORES-1:0][NB_WIDTH-1:0]  req_id,
  input  logic [NUM_CORES-1:0][NC_WIDTH-1:0]  req_size_m1,
  input  logic [NUM_CORES-1:0][NC_WIDTH-1:0]  req_core_id,
  output logic [NUM_CORES-1:0]                req_ready,
  output logic                                rsp_valid,
  output logic [NB_WIDTH-1:0]                 rsp_id
`ifdef GBAR_PERF_EN
  ,
  output logic [31:0]                         perf_releases,
  output logic [31:0]                         perf_stalls
`endif
);

  localparam int CNT_WIDTH = NC_WIDTH + 1;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } req_t;

  logic [NUM_CORES-1:0] grant;
  logic [NC_WIDTH-1:0]  grant_idx;
  logic                 grant_valid;
  logic                 accept;
  req_t                 win_req;

  vx_gbar_rr_arbiter #(
    .NUM_REQS  (NUM_CORES),
    .IDX_WIDTH (NC_WIDTH)
  ) u_rr_arb (
    .clk         (clk),
    .reset       (reset),
    .valid       (req_valid),
    .accept      (accept),
    .grant       (grant),
    .grant_index (grant_idx),
    .grant_valid (grant_valid)
  );

  // Grants are suppressed while in reset so nothing is accepted or released.
  assign accept    = grant_valid && !reset;
  assign req_ready = reset ? '0 : grant;

  always_comb begin
    win_req.id      = req_id[grant_idx];
    win_req.size_m1 = req_size_m1[grant_idx];
    win_req.core_id = req_core_id[grant_idx];
  end

  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_all;
  logic [NUM_CORES-1:0]                   new_mask;
  logic [CNT_WIDTH-1:0]                   cnt;
  logic [CNT_WIDTH-1:0]                   target;
  logic                                   release_hit;

  always_comb begin
    new_mask = mask_all[win_req.id] | (NUM_CORES'(1) << win_req.core_id);
    cnt      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cnt = cnt + CNT_WIDTH'(new_mask[i]);
    end
    target      = CNT_WIDTH'(win_req.size_m1) + CNT_WIDTH'(1);
    release_hit = accept && (cnt == target);
  end

  generate
    for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_mask
      logic [NUM_CORES-1:0] mask_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          mask_reg <= '0;
        end else if (accept && (win_req.id == NB_WIDTH'(gi))) begin
          mask_reg <= release_hit ? '0 : new_mask;
        end
      end

      assign mask_all[gi] = mask_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= release_hit;
      if (release_hit) begin
        rsp_id <= win_req.id;
      end
    end
  end

`ifdef GBAR_PERF_EN
  logic stall;
  assign stall = |(req_valid & ~req_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_releases <= '0;
      perf_stalls   <= '0;
    end else begin
      if (rsp_valid && (perf_releases != '1)) begin
        perf_releases <= perf_releases + 32'd1;
      end
      if (stall && (perf_stalls != '1)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`else
  // Counters and their ports are absent in this build.
`endif

endmodule
